// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: pipeline sequencing controller for the five-stage MIPS core.
// Drives the load enables and flushes of the PC, IF/ID, ID/EX and EX/MEM registers.
// It resolves load-use hazards, branch/jump redirects and multi-cycle data-memory
// waits. It is the only block that may stall or bubble ID/EX.
//
// Optional feature macro: HAZARD_PERF_CNT_EN (adds the stall/flush performance
// counters; when undefined both counter outputs are tied to zero).
//
// Ports:
//   clk, reset            clock (rising edge), asynchronous active-low reset
//   id_rs, id_rt          source register fields of the instruction in ID
//   id_uses_rs/rt         ID instruction actually reads RS / RT
//   ex_mem_read, ex_rd    instruction in EX is a load, and its destination
//   jump_id               J/JAL/JR decoded in ID
//   branch_taken_ex       branch resolved taken in EX
//   mem_req, mem_ready    MEM-stage data access request / completion
//   pc_we .. ex_mem_we    pipeline register load enables (combinational)
//   if_id_flush           IF/ID loads a NOP (combinational)
//   id_ex_flush           ID/EX loads a bubble (combinational)
//   mem_timeout           sticky memory-timeout error flag (registered)
//   state_o               current FSM state (RUN=0, MEM_WAIT=1, ERROR=2)
//   stall_cnt, flush_cnt  performance counters
module hazard_stall_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rd,
    input  logic             jump_id,
    input  logic             branch_taken_ex,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_we,
    output logic             if_id_we,
    output logic             if_id_flush,
    output logic             id_ex_we,
    output logic             id_ex_flush,
    output logic             ex_mem_we,
    output logic             mem_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned WAIT_W = 16;
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic [WAIT_W-1:0] wait_inc;
    logic              mem_ok;
    logic              mem_ok_nxt;
    logic              timeout_nxt;
    logic              lu;
    logic              if_id_flush_raw;
    logic              id_ex_flush_raw;

    // Load-use hazard: a load in EX writes a register the ID instruction reads.
    assign lu = ex_mem_read && (ex_rd != 5'd0) &&
                ((id_uses_rs && (id_rs == ex_rd)) || (id_uses_rt && (id_rt == ex_rd)));

    // Saturating wait-cycle count including the current MEM_WAIT cycle.
    assign wait_inc = (wait_cnt >= WAIT_LIMIT) ? wait_cnt : (wait_cnt + WAIT_W'(1));

    // State, wait counter, post-wait marker and sticky timeout flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_ok      <= 1'b0;
            mem_timeout <= 1'b0;
        end else begin
            state       <= state_nxt;
            wait_cnt    <= wait_nxt;
            mem_ok      <= mem_ok_nxt;
            mem_timeout <= timeout_nxt;
        end
    end

    // Next-state and pipeline control decode.
    always_comb begin
        state_nxt       = state;
        wait_nxt        = wait_cnt;
        mem_ok_nxt      = 1'b0;
        timeout_nxt     = mem_timeout;
        pc_we           = 1'b0;
        if_id_we        = 1'b0;
        id_ex_we        = 1'b0;
        ex_mem_we       = 1'b0;
        if_id_flush_raw = 1'b0;
        id_ex_flush_raw = 1'b0;

        case (state)
            ST_RUN: begin
                // mem_ok marks the cycle right after a completed wait: the
                // access has finished, so the memory condition counts as met.
                if (mem_req && !mem_ready && !mem_ok) begin
                    state_nxt = ST_MEM_WAIT;
                    wait_nxt  = '0;
                end else if (branch_taken_ex) begin
                    pc_we           = 1'b1;
                    if_id_we        = 1'b1;
                    id_ex_we        = 1'b1;
                    ex_mem_we       = 1'b1;
                    if_id_flush_raw = 1'b1;
                    id_ex_flush_raw = 1'b1;
                end else if (lu) begin
                    id_ex_we        = 1'b1;
                    ex_mem_we       = 1'b1;
                    id_ex_flush_raw = 1'b1;
                end else if (jump_id) begin
                    pc_we           = 1'b1;
                    if_id_we        = 1'b1;
                    id_ex_we        = 1'b1;
                    ex_mem_we       = 1'b1;
                    if_id_flush_raw = 1'b1;
                end else begin
                    pc_we     = 1'b1;
                    if_id_we  = 1'b1;
                    id_ex_we  = 1'b1;
                    ex_mem_we = 1'b1;
                end
            end

            ST_MEM_WAIT: begin
                // Pipeline frozen; hazard inputs are ignored here.
                wait_nxt = wait_inc;
                if (mem_ready) begin
                    state_nxt  = ST_RUN;
                    mem_ok_nxt = 1'b1;
                end else if (wait_inc == WAIT_LIMIT) begin
                    state_nxt   = ST_ERROR;
                    timeout_nxt = 1'b1;
                end
            end

            ST_ERROR: begin
                // Terminal until reset.
                state_nxt = ST_ERROR;
            end

            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // A flush only takes effect when its register actually loads.
    assign if_id_flush = if_id_flush_raw && if_id_we;
    assign id_ex_flush = id_ex_flush_raw && id_ex_we;

    assign state_o = state;

`ifdef HAZARD_PERF_CNT_EN
    // Performance counters, wrapping modulo 2^CNT_W.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!pc_we && (state != ST_ERROR)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (if_id_flush || id_ex_flush) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
module tb_hazard_stall_ctrl;

    localparam int unsigned CNT_W = 32;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset;
    logic [4:0]       id_rs, id_rt, ex_rd;
    logic             id_uses_rs, id_uses_rt, ex_mem_read;
    logic             jump_id, branch_taken_ex, mem_req, mem_ready;
    logic             pc_we, if_id_we, if_id_flush, id_ex_we, id_ex_flush, ex_mem_we;
    logic             mem_timeout;
    logic [1:0]       state_o;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.TIMEOUT_CYCLES(4), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .ex_mem_read(ex_mem_read), .ex_rd(ex_rd), .jump_id(jump_id),
        .branch_taken_ex(branch_taken_ex), .mem_req(mem_req), .mem_ready(mem_ready),
        .pc_we(pc_we), .if_id_we(if_id_we), .if_id_flush(if_id_flush),
        .id_ex_we(id_ex_we), .id_ex_flush(id_ex_flush), .ex_mem_we(ex_mem_we),
        .mem_timeout(mem_timeout), .state_o(state_o),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // {pc_we, if_id_we, id_ex_we, ex_mem_we}
    function automatic logic [31:0] wev();
        return 32'({pc_we, if_id_we, id_ex_we, ex_mem_we});
    endfunction

    // {if_id_flush, id_ex_flush}
    function automatic logic [31:0] flv();
        return 32'({if_id_flush, id_ex_flush});
    endfunction

    function automatic logic [31:0] ce(input int n);
        return PERF ? 32'(n) : 32'd0;
    endfunction

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; ex_rd = 5'd0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; ex_mem_read = 1'b0;
        jump_id = 1'b0; branch_taken_ex = 1'b0; mem_req = 1'b0; mem_ready = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        #3;
        chk("rst_state", 32'(state_o), 0);
        chk("rst_timeout", 32'(mem_timeout), 0);
        chk("rst_stall", 32'(stall_cnt), 0);
        chk("rst_flush", 32'(flush_cnt), 0);
        chk("rst_we_run", wev(), 32'hF);
        #9 reset = 1'b1;
        nxt();

        // Idle pipeline
        idle(); #1;
        chk("idle_we", wev(), 32'hF);
        chk("idle_fl", flv(), 0);
        nxt();

        // Load-use through RS
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; #1;
        chk("lu_rs_we", wev(), 32'h3);
        chk("lu_rs_fl", flv(), 32'h1);
        nxt();
        idle(); #1;
        chk("lu_after_we", wev(), 32'hF);
        chk("lu_stall_cnt", 32'(stall_cnt), ce(1));
        chk("lu_flush_cnt", 32'(flush_cnt), ce(1));
        nxt();

        // Load to r0 never stalls
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1; #1;
        chk("r0_we", wev(), 32'hF);
        chk("r0_fl", flv(), 0);
        nxt();

        // Load-use through RT
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; id_uses_rt = 1'b1; #1;
        chk("lu_rt_we", wev(), 32'h3);
        nxt();
        // Same registers but RT not read: no hazard
        idle(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rt = 5'd5; #1;
        chk("rt_unused_we", wev(), 32'hF);
        nxt();

        // Branch overrides load-use and jump
        idle(); branch_taken_ex = 1'b1; jump_id = 1'b1;
        ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; id_uses_rs = 1'b1; #1;
        chk("br_we", wev(), 32'hF);
        chk("br_fl", flv(), 32'h3);
        nxt();
        idle(); #1;
        chk("br_flush_cnt", 32'(flush_cnt), ce(3));
        chk("br_stall_cnt", 32'(stall_cnt), ce(2));
        nxt();

        // Jump alone
        idle(); jump_id = 1'b1; #1;
        chk("jmp_we", wev(), 32'hF);
        chk("jmp_fl", flv(), 32'h2);
        nxt();

        // Memory wait: issue cycle with a branch pending (memory wins)
        idle(); mem_req = 1'b1; branch_taken_ex = 1'b1; #1;
        chk("mw_issue_we", wev(), 0);
        chk("mw_issue_fl", flv(), 0);
        chk("mw_issue_st", 32'(state_o), 0);
        nxt();
        for (int i = 0; i < 3; i++) begin
            mem_ready = (i == 2); #1;
            chk("mw_wait_st", 32'(state_o), 1);
            chk("mw_wait_we", wev(), 0);
            chk("mw_wait_fl", flv(), 0);
            nxt();
        end
        // Back in RUN: pending branch applies
        idle(); branch_taken_ex = 1'b1; #1;
        chk("mw_ret_st", 32'(state_o), 0);
        chk("mw_ret_we", wev(), 32'hF);
        chk("mw_ret_fl", flv(), 32'h3);
        chk("mw_stall_cnt", 32'(stall_cnt), ce(6));
        chk("mw_flush_cnt", 32'(flush_cnt), ce(4));
        nxt();

        // Zero-wait access stays in RUN
        idle(); mem_req = 1'b1; mem_ready = 1'b1; #1;
        chk("zw_we", wev(), 32'hF);
        chk("zw_flush_cnt", 32'(flush_cnt), ce(5));
        nxt();
        idle(); #1;
        chk("zw_st", 32'(state_o), 0);
        nxt();

        // Timeout after 4 wait cycles
        idle(); mem_req = 1'b1; #1;
        chk("to_issue_we", wev(), 0);
        nxt();
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("to_wait_st", 32'(state_o), 1);
            chk("to_wait_flag", 32'(mem_timeout), 0);
            nxt();
        end
        mem_ready = 1'b1; #1;
        chk("to_err_st", 32'(state_o), 2);
        chk("to_err_flag", 32'(mem_timeout), 1);
        chk("to_err_we", wev(), 0);
        nxt();
        idle(); branch_taken_ex = 1'b1; #1;
        chk("to_hold_st", 32'(state_o), 2);
        chk("to_hold_fl", flv(), 0);
        chk("to_stall_cnt", 32'(stall_cnt), ce(11));
        reset = 1'b0; #1;
        chk("to_rst_st", 32'(state_o), 0);
        chk("to_rst_flag", 32'(mem_timeout), 0);
        chk("to_rst_stall", 32'(stall_cnt), 0);
        reset = 1'b1;
        nxt();

        // Asynchronous reset in MEM_WAIT
        idle(); mem_req = 1'b1; #1;
        chk("ar_issue_st", 32'(state_o), 0);
        nxt();
        #1;
        chk("ar_wait_st", 32'(state_o), 1);
        chk("ar_wait_stall", 32'(stall_cnt), ce(1));
        idle(); reset = 1'b0; #1;
        chk("ar_rst_st", 32'(state_o), 0);
        chk("ar_rst_stall", 32'(stall_cnt), 0);
        chk("ar_rst_we", wev(), 32'hF);
        reset = 1'b1;
        nxt();
        #1;
        chk("ar_after_st", 32'(state_o), 0);
        chk("ar_after_we", wev(), 32'hF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It drives the write-enable and flush controls of the PC, IF/ID, ID/EX and EX/MEM registers. It resolves load-use hazards, taken-branch and jump redirects, and multi-cycle data-memory waits. It sits beside the ID/EX register and is the only block allowed to stall or bubble it: a bubble clears ID/EX ControlSignals to 0.

## Interface
- TIMEOUT_CYCLES, 255: maximum MEM_WAIT cycles before the timeout error is raised; range 1..65535.
- CNT_W, 32: width of the performance counters.

- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-low.
- id_rs  input  5  RS field of the instruction in ID.
- id_rt  input  5  RT field of the instruction in ID.
- id_uses_rs  input  1  ID instruction reads RS.
- id_uses_rt  input  1  ID instruction reads RT.
- ex_mem_read  input  1  instruction in EX is a load.
- ex_rd  input  5  destination register of the instruction in EX.
- jump_id  input  1  J/JAL/JR decoded in ID.
- branch_taken_ex  input  1  branch resolved taken in EX.
- mem_req  input  1  MEM stage issues a data-memory access this cycle.
- mem_ready  input  1  data memory completes the access.
- pc_we  output  1  PC load enable.
- if_id_we  output  1  IF/ID load enable.
- if_id_flush  output  1  IF/ID loads a NOP.
- id_ex_we  output  1  ID/EX load enable.
- id_ex_flush  output  1  ID/EX loads a bubble.
- ex_mem_we  output  1  EX/MEM load enable.
- mem_timeout  output  1  sticky error flag.
- state_o  output  2  current FSM state.
- stall_cnt  output  CNT_W  stall cycles counted.
- flush_cnt  output  CNT_W  flush events counted.

## Operation
- States (state_o encoding): RUN=0, MEM_WAIT=1, ERROR=2. Code 3 is unreachable and recovers to RUN.
- Load-use hazard, lu: ex_mem_read & ex_rd≠0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd)).
- Outputs are combinational from the registered state and the current inputs.
- RUN, evaluated in priority order:
  1. mem_req & !mem_ready: all four *_we=0, no flush, go to MEM_WAIT.
  2. branch_taken_ex: pc_we=1, if_id_flush=1, id_ex_flush=1, all we=1. Overrides lu and jump_id.
  3. lu: pc_we=0, if_id_we=0, id_ex_flush=1, id_ex_we=1, ex_mem_we=1.
  4. jump_id: if_id_flush=1, all we=1.
  5. Otherwise all we=1, no flush.
- mem_req & mem_ready in the same cycle is a zero-wait access. It is handled as if no memory wait occurred, and the FSM stays in RUN.
- MEM_WAIT: all *_we=0 and flushes=0; the pipeline is frozen and every hazard input is ignored. The wait counter increments each cycle.
  - mem_ready=1: leave to RUN next cycle. That cycle's outputs are evaluated as RUN with the memory condition satisfied, so a pending branch or lu is applied then.
  - Wait counter reaches TIMEOUT_CYCLES with mem_ready still 0: go to ERROR.
- ERROR: all we=0, mem_timeout=1. Leave only by reset.
- Wait counter: 16 bits; clears on entry to MEM_WAIT and saturates at TIMEOUT_CYCLES.
- Flush output: the *_flush outputs are qualified by the matching *_we. A flush is never asserted while that register is frozen.

## Timing
- Reset (async, reset=0): state=RUN, wait counter=0, mem_timeout=0, stall_cnt=0, flush_cnt=0.
- During reset, combinational outputs evaluate as in RUN with the current inputs.
- A lu stall lasts exactly one cycle. After the bubble the load advances to MEM, so lu deasserts naturally.
- An N-cycle memory wait freezes the pipeline for N cycles. ready after k wait cycles gives k cycles in MEM_WAIT plus the issue cycle.
- Timeout: mem_timeout rises on the clock edge at which the wait counter equals TIMEOUT_CYCLES and mem_ready=0.
- A reset assertion mid-MEM_WAIT or in ERROR returns the block to RUN immediately (asynchronously).

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt increments on every clock where pc_we=0 and state≠ERROR.
  - flush_cnt increments on every clock where if_id_flush|id_ex_flush.
  - Both counters wrap modulo 2^CNT_W.
- HAZARD_PERF_CNT_EN undefined: stall_cnt and flush_cnt are tied to 0 and no counter flops exist.

## Test plan
- Load-use: ex_mem_read=1, ex_rd=8, id_rs=8, id_uses_rs=1 -> one cycle with pc_we=0, if_id_we=0, id_ex_flush=1; next cycle all we=1. With HAZARD_PERF_CNT_EN, stall_cnt=1.
- ex_rd=0 with matching id_rs=0 and ex_mem_read=1 -> no stall, all we=1.
- branch_taken_ex=1 together with lu=1 and jump_id=1 -> pc_we=1, if_id_flush=1, id_ex_flush=1; flush_cnt +1.
- mem_req=1, mem_ready held low 3 cycles then high -> state_o=1 for 3 cycles with all we=0, then RUN and all we=1.
- TIMEOUT_CYCLES=4, mem_ready never asserted -> state_o=2 and mem_timeout=1 after the 4th wait cycle; stays there until reset=0, then state_o=0 and mem_timeout=0.
- reset asserted during MEM_WAIT -> state_o=0 and counters=0 asynchronously, before the next clock edge.
